// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max pooling over raster-order pixels.
// Row pairs are combined through a half-width line buffer of horizontal maxima.
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int unsigned HALF_W = IMG_WIDTH / 2;
  localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
  localparam int unsigned LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         frame_done_q, frame_done_d;
  logic signed [DATA_WIDTH-1:0] lb_q [HALF_W];

  logic signed [DATA_WIDTH-1:0] pix, hm, lb_rd, vm;
  logic [LB_AW-1:0]             lb_idx;
  logic                         col_last, row_last, lb_we;

  always_comb begin
    pix      = $signed(in_data);
    lb_idx   = LB_AW'(col_q >> 1);
    lb_rd    = lb_q[lb_idx];
    hm       = (pix > hold_q) ? pix : hold_q;
    vm       = (hm > lb_rd) ? hm : lb_rd;
    col_last = (col_q == COL_W'(IMG_WIDTH - 1));
    row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));

    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    lb_we        = 1'b0;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    out_data_d   = out_data_q;

    if (in_valid) begin
      col_d = col_last ? '0 : col_q + COL_W'(1);
      if (col_last) begin
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end
      // Even column: park the left pixel; odd column: even rows fill the
      // line buffer, odd rows close the window against it.
      if (!col_q[0]) begin
        hold_d = pix;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = vm;
        frame_done_d = col_last && row_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Not reset: each entry is rewritten on an even row before any odd-row read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= hm;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;

endmodule
